swarm_enemy_controller: RTL and testbench

Parametrised successor to the single-row enemy block. It manages ENEMY_COUNT enemies, each with its own state machine: bounce movement with a descent step at each wall, multi-hit health, an invulnerable hit-flash window, timed respawn and kill scoring. It sits between the player bullet controller and the sprite renderer. It takes flattened bullet positions and returns flattened enemy positions, status flags and per-bullet hit pulses.

---
 rtl/swarm_enemy_controller.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_swarm_enemy_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swarm_enemy_controller.sv
// swarm_enemy_controller
// Manages ENEMY_COUNT enemies that bounce between X_MIN and X_MAX, descend
// DROP pixels at every wall reversal, take HIT_POINTS hits (with an
// invulnerable flash window between hits) and optionally respawn after
// RESPAWN_TICKS move ticks. Bullet/enemy collisions are arbitrated so that a
// bullet hits at most one enemy and an enemy takes at most one hit per cycle.
module swarm_enemy_controller #(
   parameter int ENEMY_COUNT   = 4,
   parameter int BULLET_COUNT  = 8,
   parameter int MOVE_PERIOD   = 500000,
   parameter int STEP          = 2,
   parameter int DROP          = 8,
   parameter int X_MIN         = 10,
   parameter int X_MAX         = 598,
   parameter int Y_MAX         = 400,
   parameter int START_X       = 60,
   parameter int START_DX      = 120,
   parameter int START_Y       = 100,
   parameter int ENEMY_SIZE    = 32,
   parameter int BULLET_SIZE   = 8,
   parameter int HIT_POINTS    = 1,
   parameter int FLASH_TICKS   = 4,
   parameter int RESPAWN_TICKS = 0
) (
   input  logic                      clk25,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [10*BULLET_COUNT-1:0] bullet_x_flat,
   input  logic [10*BULLET_COUNT-1:0] bullet_y_flat,
   input  logic [BULLET_COUNT-1:0]   bullet_active_flat,
   output logic [10*ENEMY_COUNT-1:0] enemy_x_flat,
   output logic [10*ENEMY_COUNT-1:0] enemy_y_flat,
   output logic [ENEMY_COUNT-1:0]    enemy_alive,
   output logic [ENEMY_COUNT-1:0]    enemy_flash,
   output logic [BULLET_COUNT-1:0]   bullet_hit,
   output logic                      kill_pulse,
   output logic [15:0]               kill_count,
   output logic                      wave_clear,
   output logic                      invaded
);

   localparam logic [1:0] ST_ALIVE = 2'd0;
   localparam logic [1:0] ST_FLASH = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;

   localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(MOVE_PERIOD - 1);

   // Spawn x of enemy idx; the same value is used at reset and on respawn.
   function automatic logic [9:0] spawn_x(input int idx);
      int v;
      v = START_X + idx * START_DX;
      return v[9:0];
   endfunction

   // Tick counter
   logic [CW-1:0] r_tick_cnt;
   logic          w_tick;

   // Per-enemy registered state
   logic [1:0]             r_state [ENEMY_COUNT];
   logic [9:0]             r_x     [ENEMY_COUNT];
   logic [9:0]             r_y     [ENEMY_COUNT];
   logic [ENEMY_COUNT-1:0] r_dir_right;
   logic [3:0]             r_hp    [ENEMY_COUNT];
   logic [15:0]            r_tmr   [ENEMY_COUNT];

   // Next-state values
   logic [1:0]             w_state_nx [ENEMY_COUNT];
   logic [9:0]             w_x_nx     [ENEMY_COUNT];
   logic [9:0]             w_y_nx     [ENEMY_COUNT];
   logic [ENEMY_COUNT-1:0] w_dir_nx;
   logic [3:0]             w_hp_nx    [ENEMY_COUNT];
   logic [15:0]            w_tmr_nx   [ENEMY_COUNT];

   // Collision / arbitration results
   logic [ENEMY_COUNT-1:0]  w_target [BULLET_COUNT];
   logic [ENEMY_COUNT-1:0]  w_hit_enemy;
   logic [BULLET_COUNT-1:0] w_hit_bullet;

   // Aggregate next-state flags
   logic [ENEMY_COUNT-1:0] w_kill;
   logic [15:0]            w_kill_num;
   logic [16:0]            w_kc_sum;
   logic [15:0]            w_kc_nx;
   logic [ENEMY_COUNT-1:0] w_alive_nx;
   logic [ENEMY_COUNT-1:0] w_flash_nx;
   logic                   w_wave_nx;
   logic                   w_inv_nx;

   assign w_tick = enable && (r_tick_cnt == TICK_LAST);

   // Move-tick counter: runs 0..MOVE_PERIOD-1 while enabled, holds otherwise.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
      end else if (enable) begin
         if (w_tick) begin
            r_tick_cnt <= '0;
         end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
         end
      end
   end

   // Collision detection then two-level arbitration: bullet picks lowest enemy,
   // enemy accepts lowest bullet among those targeting it.
   always_comb begin
      logic [10:0] w_bx, w_by, w_ex, w_ey;
      logic        w_found;
      logic        w_taken;
      w_hit_enemy  = '0;
      w_hit_bullet = '0;
      w_bx = 11'd0;
      w_by = 11'd0;
      w_ex = 11'd0;
      w_ey = 11'd0;
      for (int j = 0; j < BULLET_COUNT; j++) begin
         w_target[j] = '0;
         w_found     = 1'b0;
         for (int i = 0; i < ENEMY_COUNT; i++) begin
            w_bx = {1'b0, bullet_x_flat[j*10 +: 10]};
            w_by = {1'b0, bullet_y_flat[j*10 +: 10]};
            w_ex = {1'b0, r_x[i]};
            w_ey = {1'b0, r_y[i]};
            if (!w_found && enable && bullet_active_flat[j] && (r_state[i] == ST_ALIVE)
                && (w_bx <= w_ex + 11'(ENEMY_SIZE - 1)) && (w_bx + 11'(BULLET_SIZE - 1) >= w_ex)
                && (w_by <= w_ey + 11'(ENEMY_SIZE - 1)) && (w_by + 11'(BULLET_SIZE - 1) >= w_ey)) begin
               w_target[j][i] = 1'b1;
               w_found        = 1'b1;
            end else begin
               w_target[j][i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < ENEMY_COUNT; i++) begin
         w_taken = 1'b0;
         for (int j = 0; j < BULLET_COUNT; j++) begin
            if (!w_taken && w_target[j][i]) begin
               w_hit_enemy[i]  = 1'b1;
               w_hit_bullet[j] = 1'b1;
               w_taken         = 1'b1;
            end else begin
               w_taken = w_taken;
            end
         end
      end
   end

   // Per-enemy next state: hits take priority over movement on the same cycle.
   always_comb begin
      logic [10:0] w_xs;
      logic [10:0] w_ys;
      logic [9:0]  w_y_drop;
      w_kill     = '0;
      w_kill_num = 16'd0;
      w_dir_nx   = r_dir_right;
      w_xs       = 11'd0;
      w_ys       = 11'd0;
      w_y_drop   = 10'd0;
      for (int i = 0; i < ENEMY_COUNT; i++) begin
         w_state_nx[i] = r_state[i];
         w_x_nx[i]     = r_x[i];
         w_y_nx[i]     = r_y[i];
         w_hp_nx[i]    = r_hp[i];
         w_tmr_nx[i]   = r_tmr[i];
         w_xs     = {1'b0, r_x[i]} + 11'(STEP);
         w_ys     = {1'b0, r_y[i]} + 11'(DROP);
         w_y_drop = (w_ys > 11'd1023) ? 10'd1023 : w_ys[9:0];
         case (r_state[i])
            ST_ALIVE: begin
               if (w_hit_enemy[i]) begin
                  w_tmr_nx[i] = 16'd0;
                  if (r_hp[i] > 4'd1) begin
                     w_hp_nx[i]    = r_hp[i] - 4'd1;
                     w_state_nx[i] = ST_FLASH;
                  end else begin
                     w_state_nx[i] = ST_DEAD;
                     w_kill[i]     = 1'b1;
                  end
               end else if (w_tick) begin
                  if (r_dir_right[i]) begin
                     if (w_xs > 11'(X_MAX)) begin
                        w_x_nx[i]   = 10'(X_MAX);
                        w_dir_nx[i] = 1'b0;
                        w_y_nx[i]   = w_y_drop;
                     end else begin
                        w_x_nx[i] = w_xs[9:0];
                     end
                  end else begin
                     // x - STEP < X_MIN, rearranged so nothing underflows
                     if ({1'b0, r_x[i]} < 11'(X_MIN) + 11'(STEP)) begin
                        w_x_nx[i]   = 10'(X_MIN);
                        w_dir_nx[i] = 1'b1;
                        w_y_nx[i]   = w_y_drop;
                     end else begin
                        w_x_nx[i] = r_x[i] - 10'(STEP);
                     end
                  end
               end else begin
                  w_state_nx[i] = ST_ALIVE;
               end
            end
            ST_FLASH: begin
               if (w_tick) begin
                  if (r_tmr[i] + 16'd1 >= 16'(FLASH_TICKS)) begin
                     w_state_nx[i] = ST_ALIVE;
                     w_tmr_nx[i]   = 16'd0;
                  end else begin
                     w_tmr_nx[i] = r_tmr[i] + 16'd1;
                  end
               end else begin
                  w_state_nx[i] = ST_FLASH;
               end
            end
            ST_DEAD: begin
               if ((RESPAWN_TICKS != 0) && w_tick) begin
                  if (r_tmr[i] + 16'd1 >= 16'(RESPAWN_TICKS)) begin
                     w_state_nx[i] = ST_ALIVE;
                     w_x_nx[i]     = spawn_x(i);
                     w_y_nx[i]     = 10'(START_Y);
                     w_dir_nx[i]   = 1'b1;
                     w_hp_nx[i]    = 4'(HIT_POINTS);
                     w_tmr_nx[i]   = 16'd0;
                  end else begin
                     w_tmr_nx[i] = r_tmr[i] + 16'd1;
                  end
               end else begin
                  w_state_nx[i] = ST_DEAD;
               end
            end
            default: begin
               // Corrupted encoding: park the enemy safely out of play.
               w_state_nx[i] = ST_DEAD;
               w_tmr_nx[i]   = 16'd0;
            end
         endcase
         if (w_kill[i]) begin
            w_kill_num = w_kill_num + 16'd1;
         end else begin
            w_kill_num = w_kill_num;
         end
      end
   end

   // Aggregate flags derived from next state so they line up with the state registers.
   always_comb begin
      w_wave_nx = 1'b1;
      w_inv_nx  = 1'b0;
      for (int i = 0; i < ENEMY_COUNT; i++) begin
         w_alive_nx[i] = (w_state_nx[i] != ST_DEAD);
         w_flash_nx[i] = (w_state_nx[i] == ST_FLASH);
         if (w_alive_nx[i]) begin
            w_wave_nx = 1'b0;
            w_inv_nx  = w_inv_nx | (w_y_nx[i] >= 10'(Y_MAX));
         end else begin
            w_inv_nx  = w_inv_nx;
         end
      end
      w_kc_sum = {1'b0, kill_count} + {1'b0, w_kill_num};
      w_kc_nx  = w_kc_sum[16] ? 16'hFFFF : w_kc_sum[15:0];
   end

   // Per-enemy state registers.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         r_dir_right <= '1;
         for (int i = 0; i < ENEMY_COUNT; i++) begin
            r_state[i] <= ST_ALIVE;
            r_x[i]     <= spawn_x(i);
            r_y[i]     <= 10'(START_Y);
            r_hp[i]    <= 4'(HIT_POINTS);
            r_tmr[i]   <= 16'd0;
         end
      end else begin
         r_dir_right <= w_dir_nx;
         for (int i = 0; i < ENEMY_COUNT; i++) begin
            r_state[i] <= w_state_nx[i];
            r_x[i]     <= w_x_nx[i];
            r_y[i]     <= w_y_nx[i];
            r_hp[i]    <= w_hp_nx[i];
            r_tmr[i]   <= w_tmr_nx[i];
         end
      end
   end

   // Registered status outputs and hit/kill pulses.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         bullet_hit  <= '0;
         kill_pulse  <= 1'b0;
         kill_count  <= 16'd0;
         wave_clear  <= 1'b0;
         invaded     <= 1'b0;
         enemy_alive <= '1;
         enemy_flash <= '0;
      end else begin
         bullet_hit  <= w_hit_bullet;
         kill_pulse  <= |w_kill;
         kill_count  <= w_kc_nx;
         wave_clear  <= w_wave_nx;
         invaded     <= w_inv_nx;
         enemy_alive <= w_alive_nx;
         enemy_flash <= w_flash_nx;
      end
   end

   for (genvar g = 0; g < ENEMY_COUNT; g++) begin : g_flat
      assign enemy_x_flat[g*10 +: 10] = r_x[g];
      assign enemy_y_flat[g*10 +: 10] = r_y[g];
   end

endmodule

// File: tb/tb_swarm_enemy_controller.sv
// Bench for swarm_enemy_controller: directed scenarios plus randomized bullets
// compared against a plain-integer behavioural model of the enemy swarm.
module tb_swarm_enemy_controller;
   localparam int NE = 4, NB = 8, MP = 4, STEP = 2, DROP = 8, XMIN = 10, XMAX = 440;
   localparam int YMAX = 108, SX = 60, SDX = 120, SY = 100, ES = 32, BS = 8;
   localparam int HP = 2, FT = 2, RT = 3;
   localparam logic [10*NE-1:0] SPAWN_XF = {10'd420, 10'd300, 10'd180, 10'd60};

   logic clk25 = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic [10*NB-1:0] bx_flat = '0;
   logic [10*NB-1:0] by_flat = '0;
   logic [NB-1:0]    bact = '0;
   logic [10*NE-1:0] enemy_x_flat, enemy_y_flat;
   logic [NE-1:0]    enemy_alive, enemy_flash;
   logic [NB-1:0]    bullet_hit;
   logic             kill_pulse, wave_clear, invaded;
   logic [15:0]      kill_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Behavioural model: state 0 alive, 1 flash, 2 dead
   int m_st[NE], m_x[NE], m_y[NE], m_dir[NE], m_hp[NE], m_tmr[NE];
   int m_cnt, m_kc;
   logic [NB-1:0] m_bhit;
   logic m_kp, m_wc, m_inv;

   swarm_enemy_controller #(
      .ENEMY_COUNT(NE), .BULLET_COUNT(NB), .MOVE_PERIOD(MP), .STEP(STEP), .DROP(DROP),
      .X_MIN(XMIN), .X_MAX(XMAX), .Y_MAX(YMAX), .START_X(SX), .START_DX(SDX),
      .START_Y(SY), .ENEMY_SIZE(ES), .BULLET_SIZE(BS), .HIT_POINTS(HP),
      .FLASH_TICKS(FT), .RESPAWN_TICKS(RT)
   ) dut (
      .clk25(clk25), .reset_n(reset_n), .enable(enable),
      .bullet_x_flat(bx_flat), .bullet_y_flat(by_flat), .bullet_active_flat(bact),
      .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat),
      .enemy_alive(enemy_alive), .enemy_flash(enemy_flash), .bullet_hit(bullet_hit),
      .kill_pulse(kill_pulse), .kill_count(kill_count), .wave_clear(wave_clear),
      .invaded(invaded)
   );

   always #5 clk25 = ~clk25;

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   function automatic void respawn(int i);
      m_st[i] = 0; m_x[i] = SX + i * SDX; m_y[i] = SY;
      m_dir[i] = 1; m_hp[i] = HP; m_tmr[i] = 0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NE; i++) respawn(i);
      m_cnt = 0; m_kc = 0; m_bhit = '0; m_kp = 1'b0; m_wc = 1'b0; m_inv = 1'b0;
   endfunction

   function automatic bit overlap(int bx, int by, int ex, int ey);
      return (bx <= ex + ES - 1) && (bx + BS - 1 >= ex) && (by <= ey + ES - 1) && (by + BS - 1 >= ey);
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   function automatic void model_step();
      bit tick;
      bit claimed[NE];
      int kills, tgt, bx, by;
      tick = enable && (m_cnt == MP - 1);
      if (enable) m_cnt = tick ? 0 : m_cnt + 1;
      m_bhit = '0;
      kills = 0;
      for (int i = 0; i < NE; i++) claimed[i] = 1'b0;
      for (int j = 0; j < NB; j++) begin
         if (enable && bact[j]) begin
            bx = int'(bx_flat[j*10 +: 10]);
            by = int'(by_flat[j*10 +: 10]);
            tgt = -1;
            for (int i = 0; i < NE; i++)
               if (tgt < 0 && m_st[i] == 0 && overlap(bx, by, m_x[i], m_y[i])) tgt = i;
            if (tgt >= 0 && !claimed[tgt]) begin
               claimed[tgt] = 1'b1;
               m_bhit[j] = 1'b1;
            end
         end
      end
      for (int i = 0; i < NE; i++) begin
         if (m_st[i] == 0 && claimed[i]) begin
            m_tmr[i] = 0;
            if (m_hp[i] > 1) begin m_hp[i]--; m_st[i] = 1; end
            else begin m_st[i] = 2; kills++; end
         end else if (m_st[i] == 0 && tick) begin
            if (m_dir[i] == 1 && m_x[i] + STEP > XMAX) begin
               m_x[i] = XMAX; m_dir[i] = 0; m_y[i] = (m_y[i] + DROP > 1023) ? 1023 : m_y[i] + DROP;
            end else if (m_dir[i] == 0 && m_x[i] - STEP < XMIN) begin
               m_x[i] = XMIN; m_dir[i] = 1; m_y[i] = (m_y[i] + DROP > 1023) ? 1023 : m_y[i] + DROP;
            end else begin
               m_x[i] = (m_dir[i] == 1) ? m_x[i] + STEP : m_x[i] - STEP;
            end
         end else if (m_st[i] == 1 && tick) begin
            m_tmr[i]++;
            if (m_tmr[i] >= FT) begin m_st[i] = 0; m_tmr[i] = 0; end
         end else if (m_st[i] == 2 && tick && RT > 0) begin
            m_tmr[i]++;
            if (m_tmr[i] >= RT) respawn(i);
         end
      end
      m_kp = (kills > 0);
      m_kc = (m_kc + kills > 65535) ? 65535 : m_kc + kills;
      m_wc = 1'b1; m_inv = 1'b0;
      for (int i = 0; i < NE; i++) begin
         if (m_st[i] != 2) begin
            m_wc = 1'b0;
            if (m_y[i] >= YMAX) m_inv = 1'b1;
         end
      end
   endfunction

   function automatic logic [10*NE-1:0] exp_xf();
      logic [10*NE-1:0] v;
      for (int i = 0; i < NE; i++) v[i*10 +: 10] = 10'(m_x[i]);
      return v;
   endfunction

   function automatic logic [10*NE-1:0] exp_yf();
      logic [10*NE-1:0] v;
      for (int i = 0; i < NE; i++) v[i*10 +: 10] = 10'(m_y[i]);
      return v;
   endfunction

   function automatic logic [NE-1:0] exp_alive();
      logic [NE-1:0] v;
      for (int i = 0; i < NE; i++) v[i] = (m_st[i] != 2);
      return v;
   endfunction

   function automatic logic [NE-1:0] exp_flash();
      logic [NE-1:0] v;
      for (int i = 0; i < NE; i++) v[i] = (m_st[i] == 1);
      return v;
   endfunction

   task automatic clear_bullets();
      bact = '0;
   endtask

   // Place bullet j at model enemy i's position plus an offset, clamped to the screen.
   task automatic aim(int j, int i, int dx, int dy);
      int x, y;
      x = m_x[i] + dx; y = m_y[i] + dy;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      bx_flat[j*10 +: 10] = 10'(x);
      by_flat[j*10 +: 10] = 10'(y);
      bact[j] = 1'b1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk25);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable = 1'b1;
      clear_bullets();
      @(posedge clk25);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (enemy_x_flat !== SPAWN_XF) $display("FAIL reset_x: got %h want %h", enemy_x_flat, SPAWN_XF); else pass_cnt++;
      total_cnt++; if (enemy_y_flat !== {4{10'd100}}) $display("FAIL reset_y: got %h want %h", enemy_y_flat, {4{10'd100}}); else pass_cnt++;
      total_cnt++; if (enemy_alive !== 4'hF || enemy_flash !== 4'h0) $display("FAIL reset_status: alive %b flash %b want 1111 0000", enemy_alive, enemy_flash); else pass_cnt++;
      total_cnt++; if (bullet_hit !== 8'h00 || kill_pulse !== 1'b0 || kill_count !== 16'd0) $display("FAIL reset_hits: hit %h kp %b kc %0d want 0", bullet_hit, kill_pulse, kill_count); else pass_cnt++;
      total_cnt++; if (wave_clear !== 1'b0 || invaded !== 1'b0) $display("FAIL reset_flags: wc %b inv %b want 0 0", wave_clear, invaded); else pass_cnt++;
   endtask

   task automatic test_movement();
      do_reset();
      for (int c = 1; c <= 48; c++) begin
         cycle();
         total_cnt++; if (enemy_x_flat !== exp_xf() || enemy_y_flat !== exp_yf()) $display("FAIL move_pos c%0d: got %h/%h want %h/%h", c, enemy_x_flat, enemy_y_flat, exp_xf(), exp_yf()); else pass_cnt++;
         total_cnt++; if (invaded !== m_inv) $display("FAIL move_inv c%0d: got %b want %b", c, invaded, m_inv); else pass_cnt++;
         if (c == 44) begin
            total_cnt++; if (enemy_x_flat[39:30] !== 10'd440 || enemy_y_flat[39:30] !== 10'd108) $display("FAIL wall_reverse: got x %0d y %0d want 440 108", enemy_x_flat[39:30], enemy_y_flat[39:30]); else pass_cnt++;
            total_cnt++; if (enemy_x_flat[9:0] !== 10'd82 || invaded !== 1'b1) $display("FAIL move_e0_inv: got x %0d inv %b want 82 1", enemy_x_flat[9:0], invaded); else pass_cnt++;
         end
      end
      total_cnt++; if (enemy_x_flat[39:30] !== 10'd438) $display("FAIL move_left: got %0d want 438", enemy_x_flat[39:30]); else pass_cnt++;
   endtask

   task automatic test_flash_kill();
      do_reset();
      aim(0, 1, 4, 4);
      for (int c = 1; c <= 10; c++) begin
         cycle();
         total_cnt++; if (bullet_hit !== m_bhit || enemy_flash !== exp_flash() || enemy_alive !== exp_alive()) $display("FAIL flash_seq c%0d: hit %h fl %b al %b want %h %b %b", c, bullet_hit, enemy_flash, enemy_alive, m_bhit, exp_flash(), exp_alive()); else pass_cnt++;
         total_cnt++; if (kill_count !== 16'(m_kc) || kill_pulse !== m_kp) $display("FAIL flash_kc c%0d: kc %0d kp %b want %0d %b", c, kill_count, kill_pulse, m_kc, m_kp); else pass_cnt++;
         if (c == 1) begin
            total_cnt++; if (bullet_hit !== 8'h01 || enemy_flash !== 4'b0010) $display("FAIL first_hit: hit %h flash %b want 01 0010", bullet_hit, enemy_flash); else pass_cnt++;
         end
         if (c == 5) begin
            total_cnt++; if (bullet_hit !== 8'h00) $display("FAIL flash_invuln: hit %h want 00", bullet_hit); else pass_cnt++;
         end
         if (c == 9) begin
            total_cnt++; if (bullet_hit !== 8'h01 || enemy_alive !== 4'b1101 || kill_pulse !== 1'b1 || kill_count !== 16'd1) $display("FAIL second_hit_kill: hit %h alive %b kp %b kc %0d want 01 1101 1 1", bullet_hit, enemy_alive, kill_pulse, kill_count); else pass_cnt++;
         end
      end
      clear_bullets();
   endtask

   task automatic test_arbitration();
      do_reset();
      aim(2, 1, 0, 0);
      aim(5, 1, 10, 10);
      cycle();
      total_cnt++; if (bullet_hit !== 8'h04 || bullet_hit !== m_bhit) $display("FAIL arb_lowest: got %h want 04 (model %h)", bullet_hit, m_bhit); else pass_cnt++;
      cycle();
      total_cnt++; if (bullet_hit !== 8'h00 || bullet_hit !== m_bhit) $display("FAIL arb_loser_flash: got %h want 00", bullet_hit); else pass_cnt++;
      clear_bullets();
   endtask

   task automatic test_double_kill();
      do_reset();
      aim(0, 0, 2, 2);
      aim(1, 3, 20, 20);
      for (int c = 1; c <= 9; c++) begin
         cycle();
         total_cnt++; if (bullet_hit !== m_bhit || kill_pulse !== m_kp) $display("FAIL dbl_seq c%0d: hit %h kp %b want %h %b", c, bullet_hit, kill_pulse, m_bhit, m_kp); else pass_cnt++;
         if (c == 1) begin
            total_cnt++; if (bullet_hit !== 8'h03) $display("FAIL dbl_first: got %h want 03", bullet_hit); else pass_cnt++;
         end
      end
      total_cnt++; if (kill_pulse !== 1'b1 || kill_count !== 16'd2 || enemy_alive !== 4'b0110) $display("FAIL double_kill: kp %b kc %0d alive %b want 1 2 0110", kill_pulse, kill_count, enemy_alive); else pass_cnt++;
      clear_bullets();
      cycle();
      total_cnt++; if (kill_pulse !== 1'b0 || kill_count !== 16'd2) $display("FAIL dbl_after: kp %b kc %0d want 0 2", kill_pulse, kill_count); else pass_cnt++;
   endtask

   task automatic test_wave_respawn();
      do_reset();
      for (int j = 0; j < NE; j++) aim(j, j, 8, 8);
      for (int c = 1; c <= 20; c++) begin
         if (c == 10) clear_bullets();
         cycle();
         total_cnt++; if (wave_clear !== m_wc || enemy_alive !== exp_alive()) $display("FAIL wave_seq c%0d: wc %b al %b want %b %b", c, wave_clear, enemy_alive, m_wc, exp_alive()); else pass_cnt++;
         if (c == 9) begin
            total_cnt++; if (wave_clear !== 1'b1 || kill_count !== 16'd4 || enemy_alive !== 4'h0) $display("FAIL wave_clear: wc %b kc %0d al %b want 1 4 0000", wave_clear, kill_count, enemy_alive); else pass_cnt++;
         end
         if (c == 19) begin
            total_cnt++; if (wave_clear !== 1'b1) $display("FAIL respawn_early: wc %b want 1", wave_clear); else pass_cnt++;
         end
      end
      total_cnt++; if (wave_clear !== 1'b0 || enemy_alive !== 4'hF || enemy_x_flat !== SPAWN_XF || enemy_y_flat !== {4{10'd100}}) $display("FAIL respawn: wc %b al %b x %h y %h", wave_clear, enemy_alive, enemy_x_flat, enemy_y_flat); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      aim(0, 2, 5, 5);
      cycle();
      total_cnt++; if (enemy_flash !== 4'b0100 || bullet_hit !== 8'h01) $display("FAIL pre_reset_flash: fl %b hit %h want 0100 01", enemy_flash, bullet_hit); else pass_cnt++;
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++; if (enemy_flash !== 4'h0 || enemy_alive !== 4'hF || bullet_hit !== 8'h00 || enemy_x_flat !== SPAWN_XF) $display("FAIL async_reset: fl %b al %b hit %h x %h", enemy_flash, enemy_alive, bullet_hit, enemy_x_flat); else pass_cnt++;
      model_reset();
      clear_bullets();
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_pause();
      do_reset();
      aim(0, 0, 0, 0);
      cycle();
      clear_bullets();
      aim(1, 1, 3, 3);
      enable = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         cycle();
         total_cnt++; if (bullet_hit !== 8'h00 || enemy_x_flat !== exp_xf() || enemy_flash !== 4'b0001) $display("FAIL pause c%0d: hit %h x %h fl %b", c, bullet_hit, enemy_x_flat, enemy_flash); else pass_cnt++;
      end
      enable = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         total_cnt++; if (bullet_hit !== m_bhit || enemy_flash !== exp_flash() || enemy_x_flat !== exp_xf()) $display("FAIL resume c%0d: hit %h fl %b x %h want %h %b %h", c, bullet_hit, enemy_flash, enemy_x_flat, m_bhit, exp_flash(), exp_xf()); else pass_cnt++;
      end
      clear_bullets();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         enable = ($urandom_range(0, 9) != 0);
         for (int j = 0; j < NB; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               bx_flat[j*10 +: 10] = 10'($urandom_range(0, 1023));
               by_flat[j*10 +: 10] = 10'($urandom_range(0, 1023));
               bact[j] = 1'($urandom_range(0, 1));
            end else begin
               aim(j, $urandom_range(0, NE - 1), $urandom_range(0, 50) - 12, $urandom_range(0, 50) - 12);
               bact[j] = ($urandom_range(0, 2) != 0);
            end
         end
         cycle();
         total_cnt++; if (bullet_hit !== m_bhit || kill_pulse !== m_kp || kill_count !== 16'(m_kc)) $display("FAIL rnd_hits c%0d: hit %h kp %b kc %0d want %h %b %0d", c, bullet_hit, kill_pulse, kill_count, m_bhit, m_kp, m_kc); else pass_cnt++;
         total_cnt++; if (enemy_x_flat !== exp_xf() || enemy_y_flat !== exp_yf()) $display("FAIL rnd_pos c%0d: got %h/%h want %h/%h", c, enemy_x_flat, enemy_y_flat, exp_xf(), exp_yf()); else pass_cnt++;
         total_cnt++; if (enemy_alive !== exp_alive() || enemy_flash !== exp_flash() || wave_clear !== m_wc || invaded !== m_inv) $display("FAIL rnd_status c%0d: al %b fl %b wc %b inv %b want %b %b %b %b", c, enemy_alive, enemy_flash, wave_clear, invaded, exp_alive(), exp_flash(), m_wc, m_inv); else pass_cnt++;
      end
      clear_bullets();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_movement();
      test_flash_kill();
      test_arbitration();
      test_double_kill();
      test_wave_respawn();
      test_async_reset();
      test_pause();
      do_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
